// File: rtl/abus_initiator_if.sv
// A-bus pin group between the initiator and its responder.
// The master modport is the initiator side and the slave modport is the responder side.
interface abus_initiator_if;
    logic [25:0] AA;
    logic [15:0] ADO;
    logic [15:0] ADI;
    logic        ACS0_N;
    logic        ACS1_N;
    logic        ACS2_N;
    logic        ARD_N;
    logic        AWRL_N;
    logic        AWRU_N;
    logic        AWAIT_N;

    modport master (
        output AA, ADO, ACS0_N, ACS1_N, ACS2_N, ARD_N, AWRL_N, AWRU_N,
        input  ADI, AWAIT_N
    );

    modport slave (
        input  AA, ADO, ACS0_N, ACS1_N, ACS2_N, ARD_N, AWRL_N, AWRU_N,
        output ADI, AWAIT_N
    );
endinterface

// File: rtl/abus_initiator.sv
// A-bus initiator: runs one SETUP/STROBE/HOLD bus cycle per request, advancing only on CE_R ticks.
// Each chip select has its own minimum strobe width, and the responder can stretch the strobe up to TIMEOUT ticks.
module abus_initiator #(
    parameter int unsigned WAIT_CS0 = 3,
    parameter int unsigned WAIT_CS1 = 1,
    parameter int unsigned WAIT_CS2 = 7,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic        REQ,
    input  logic        WE,
    input  logic [1:0]  CS,
    input  logic [25:0] ADDR,
    input  logic [1:0]  BE,
    input  logic [15:0] WDATA,
    output logic [15:0] RDATA,
    output logic        ACK,
    output logic        ERR,
    output logic        BUSY,
    abus_initiator_if.master abus
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned EXT_W  = 8;
    localparam int unsigned ADDR_W = 26;
    localparam int unsigned DATA_W = 16;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_STROBE = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    localparam logic [CNT_W-1:0] WAIT0   = CNT_W'(WAIT_CS0);
    localparam logic [CNT_W-1:0] WAIT1   = CNT_W'(WAIT_CS1);
    localparam logic [CNT_W-1:0] WAIT2   = CNT_W'(WAIT_CS2);
    localparam logic [EXT_W-1:0] EXT_MAX = EXT_W'(TIMEOUT);

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        cs_q, cs_d;
    logic [1:0]        be_q, be_d;
    logic              err_flag_q, err_flag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [EXT_W-1:0]  ext_q, ext_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] aa_q, aa_d;
    logic [DATA_W-1:0] ado_q, ado_d;
    logic [2:0]        csn_q, csn_d;
    logic              ard_n_q, ard_n_d;
    logic              awrl_n_q, awrl_n_d;
    logic              awru_n_q, awru_n_d;
    logic [CNT_W-1:0]  wait_min_c;

    // Minimum strobe length for the chip select latched at request time
    always_comb begin
        case (cs_q)
            2'd0:    wait_min_c = WAIT0;
            2'd1:    wait_min_c = WAIT1;
            default: wait_min_c = WAIT2;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        cs_d       = cs_q;
        be_d       = be_q;
        err_flag_d = err_flag_q;
        cnt_d      = cnt_q;
        ext_d      = ext_q;
        rdata_d    = rdata_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        aa_d       = aa_q;
        ado_d      = ado_q;
        csn_d      = csn_q;
        ard_n_d    = 1'b1;
        awrl_n_d   = 1'b1;
        awru_n_d   = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    if (CS == 2'd3) begin
                        ack_d = 1'b1;
                        err_d = 1'b1;
                    end else begin
                        we_d       = WE;
                        cs_d       = CS;
                        be_d       = BE;
                        aa_d       = ADDR;
                        ado_d      = WDATA;
                        err_flag_d = 1'b0;
                        csn_d      = ~(3'b001 << CS);
                        state_d    = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                cnt_d    = '0;
                ext_d    = '0;
                ard_n_d  = we_q;
                awru_n_d = ~(we_q & be_q[1]);
                awrl_n_d = ~(we_q & be_q[0]);
                state_d  = S_STROBE;
            end
            S_STROBE: begin
                ard_n_d  = we_q;
                awru_n_d = ~(we_q & be_q[1]);
                awrl_n_d = ~(we_q & be_q[0]);
                if (cnt_q != wait_min_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (abus.AWAIT_N || (ext_q == EXT_MAX)) begin
                    // Normal end or wait timeout: drop strobes and go to HOLD
                    ard_n_d    = 1'b1;
                    awru_n_d   = 1'b1;
                    awrl_n_d   = 1'b1;
                    err_flag_d = ~abus.AWAIT_N;
                    if (!we_q) begin
                        rdata_d = abus.AWAIT_N ? abus.ADI : 16'hFFFF;
                    end
                    state_d = S_HOLD;
                end else begin
                    ext_d = ext_q + EXT_W'(1);
                end
            end
            default: begin
                csn_d   = 3'b111;
                ack_d   = 1'b1;
                err_d   = err_flag_q;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; ACK/ERR fall on the next CLK even without CE_R
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            cs_q       <= 2'd0;
            be_q       <= 2'd0;
            err_flag_q <= 1'b0;
            cnt_q      <= '0;
            ext_q      <= '0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            aa_q       <= '0;
            ado_q      <= '0;
            csn_q      <= 3'b111;
            ard_n_q    <= 1'b1;
            awrl_n_q   <= 1'b1;
            awru_n_q   <= 1'b1;
        end else if (CE_R) begin
            state_q    <= state_d;
            we_q       <= we_d;
            cs_q       <= cs_d;
            be_q       <= be_d;
            err_flag_q <= err_flag_d;
            cnt_q      <= cnt_d;
            ext_q      <= ext_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            aa_q       <= aa_d;
            ado_q      <= ado_d;
            csn_q      <= csn_d;
            ard_n_q    <= ard_n_d;
            awrl_n_q   <= awrl_n_d;
            awru_n_q   <= awru_n_d;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end
    end

    assign RDATA       = rdata_q;
    assign ACK         = ack_q;
    assign ERR         = err_q;
    assign BUSY        = busy_q;
    assign abus.AA     = aa_q;
    assign abus.ADO    = ado_q;
    assign abus.ACS0_N = csn_q[0];
    assign abus.ACS1_N = csn_q[1];
    assign abus.ACS2_N = csn_q[2];
    assign abus.ARD_N  = ard_n_q;
    assign abus.AWRL_N = awrl_n_q;
    assign abus.AWRU_N = awru_n_q;

endmodule

// File: tb/tb_abus_initiator.sv
// Self-checking bench for abus_initiator: a scoreboard of expected completions plus a bus monitor
// that measures chip-select, strobe and idle widths in CLK cycles.
module tb_abus_initiator;

    logic        CLK;
    logic        RST;
    logic        CE_R;
    logic        REQ;
    logic        WE;
    logic [1:0]  CS;
    logic [25:0] ADDR;
    logic [1:0]  BE;
    logic [15:0] WDATA;
    logic [15:0] RDATA;
    logic        ACK;
    logic        ERR;
    logic        BUSY;

    abus_initiator_if bus();

    abus_initiator dut (
        .CLK   (CLK),
        .RST   (RST),
        .CE_R  (CE_R),
        .REQ   (REQ),
        .WE    (WE),
        .CS    (CS),
        .ADDR  (ADDR),
        .BE    (BE),
        .WDATA (WDATA),
        .RDATA (RDATA),
        .ACK   (ACK),
        .ERR   (ERR),
        .BUSY  (BUSY),
        .abus  (bus)
    );

    typedef struct {
        logic [15:0] rdata;
        bit          chk_rd;
        bit          err;
        logic [25:0] aa;
        bit          chk_aa;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // CE_R generator: one tick every ce_period CLKs
    int ce_period = 1;
    int ce_cnt    = 0;
    bit ce_en     = 1'b0;
    always @(negedge CLK) begin
        ce_cnt = (ce_cnt + 1 >= ce_period) ? 0 : ce_cnt + 1;
        CE_R   = ce_en && (ce_cnt == 0);
    end

    // Responder: holds AWAIT_N low until the strobe has been low aw_release CLKs, or forever
    int sc         = 0;
    bit aw_stuck   = 1'b0;
    int aw_release = 0;
    always @(negedge CLK) begin
        if (!bus.ARD_N || !bus.AWRL_N || !bus.AWRU_N) sc++;
        else sc = 0;
        bus.AWAIT_N = aw_stuck ? 1'b0 : ((aw_release != 0 && sc < aw_release) ? 1'b0 : 1'b1);
    end

    // Bus monitor: run lengths in CLKs plus protocol invariants
    int cs_run = 0, cs_last = 0, idle_run = 0, idle_last = 0;
    int rd_run = 0, rd_last = 0, wl_run = 0, wl_last = 0, wu_run = 0, wu_last = 0;
    int ack_count = 0, ack_run = 0, inv_viol = 0;
    bit busy_seen = 1'b0;
    logic [2:0] mon_csn;
    always @(negedge CLK) begin
        mon_csn = {bus.ACS2_N, bus.ACS1_N, bus.ACS0_N};
        if (mon_csn != 3'b111) begin
            cs_run++;
            if (idle_run != 0) begin idle_last = idle_run; idle_run = 0; end
        end else begin
            idle_run++;
            if (cs_run != 0) begin cs_last = cs_run; cs_run = 0; end
        end
        if (!bus.ARD_N) rd_run++;
        else if (rd_run != 0) begin rd_last = rd_run; rd_run = 0; end
        if (!bus.AWRL_N) wl_run++;
        else if (wl_run != 0) begin wl_last = wl_run; wl_run = 0; end
        if (!bus.AWRU_N) wu_run++;
        else if (wu_run != 0) begin wu_last = wu_run; wu_run = 0; end
        if ($countones(~mon_csn) > 1) inv_viol++;
        if ((!bus.ARD_N || !bus.AWRL_N || !bus.AWRU_N) && (mon_csn == 3'b111 || !BUSY)) inv_viol++;
        if (ERR && !ACK) inv_viol++;
        if (ACK) begin
            ack_count++;
            ack_run++;
            if (ack_run > 1) inv_viol++;
        end else begin
            ack_run = 0;
        end
        if (BUSY) busy_seen = 1'b1;
    end

    task automatic clear_mon();
        cs_last = 0; idle_last = 0; rd_last = 0; wl_last = 0; wu_last = 0; busy_seen = 1'b0;
    endtask

    task automatic drive_req(input logic we, input logic [1:0] cs, input logic [25:0] addr,
                             input logic [1:0] be, input logic [15:0] wd, input exp_t e);
        WE = we; CS = cs; ADDR = addr; BE = be; WDATA = wd; REQ = 1'b1;
        sb.push_back(e);
    endtask

    // Waits for ACK; unless keep is set, drops REQ and scrambles the inputs once the request is taken
    task automatic wait_ack(input bit keep, input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge CLK);
            if (ACK) got = 1'b1;
            if ((BUSY || ACK) && !keep && REQ) begin
                REQ = 1'b0;
                ADDR = 26'($urandom); WDATA = 16'($urandom); BE = 2'($urandom);
                CS = 2'($urandom); WE = ~WE;
            end
        end
        #2;
    endtask

    task automatic test_reset();
        RST = 1'b1; REQ = 1'b0; WE = 1'b0; CS = 2'd0; ADDR = '0; BE = 2'b00; WDATA = '0;
        bus.ADI = '0; ce_en = 1'b0;
        repeat (3) @(negedge CLK);
        #2;
        checks++; if ({bus.ACS2_N, bus.ACS1_N, bus.ACS0_N, bus.ARD_N, bus.AWRL_N, bus.AWRU_N} !== 6'b111111) begin
            failures++; $display("FAIL reset_pins: got %b want 111111", {bus.ACS2_N, bus.ACS1_N, bus.ACS0_N, bus.ARD_N, bus.AWRL_N, bus.AWRU_N}); end
        checks++; if (bus.AA !== 26'h0 || bus.ADO !== 16'h0) begin
            failures++; $display("FAIL reset_aa_ado: got AA=%h ADO=%h want 0", bus.AA, bus.ADO); end
        checks++; if (RDATA !== 16'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", RDATA); end
        checks++; if ({ACK, ERR, BUSY} !== 3'b000) begin
            failures++; $display("FAIL reset_flags: got ACK/ERR/BUSY=%b want 000", {ACK, ERR, BUSY}); end
        RST = 1'b0; ce_en = 1'b1;
        repeat (2) @(negedge CLK);
        #2;
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_idle: got BUSY=%b want 0", BUSY); end
    endtask

    task automatic test_cs0_read();
        exp_t e; bit got;
        ce_period = 1; clear_mon(); bus.ADI = 16'hBEEF;
        e = '{rdata: 16'hBEEF, chk_rd: 1'b1, err: 1'b0, aa: 26'h0001234, chk_aa: 1'b1};
        drive_req(1'b0, 2'd0, 26'h0001234, 2'b11, 16'h0000, e);
        wait_ack(1'b0, 100, got);
        checks++; if (!got) begin failures++; $display("FAIL cs0_read_ack: no ACK within 100 CLKs"); end
        if (sb.size() != 0) e = sb.pop_front();
        checks++; if (RDATA !== e.rdata) begin failures++; $display("FAIL cs0_read_rdata: got %h want %h", RDATA, e.rdata); end
        checks++; if (ERR !== e.err) begin failures++; $display("FAIL cs0_read_err: got %b want %b", ERR, e.err); end
        checks++; if (bus.AA !== e.aa) begin failures++; $display("FAIL cs0_read_aa: got %h want %h", bus.AA, e.aa); end
        checks++; if (cs_last !== 6) begin failures++; $display("FAIL cs0_read_cs_width: got %0d want 6", cs_last); end
        checks++; if (rd_last !== 4) begin failures++; $display("FAIL cs0_read_rd_width: got %0d want 4", rd_last); end
        checks++; if (idle_run !== 1) begin failures++; $display("FAIL cs0_read_ack_align: got %0d idle CLKs at ACK want 1", idle_run); end
    endtask

    task automatic test_cs1_write();
        exp_t e; bit got;
        ce_period = 1; clear_mon();
        e = '{rdata: 16'h0, chk_rd: 1'b0, err: 1'b0, aa: 26'h2ABCDEF, chk_aa: 1'b1};
        drive_req(1'b1, 2'd1, 26'h2ABCDEF, 2'b01, 16'h55AA, e);
        wait_ack(1'b0, 100, got);
        checks++; if (!got) begin failures++; $display("FAIL cs1_write_ack: no ACK within 100 CLKs"); end
        if (sb.size() != 0) e = sb.pop_front();
        checks++; if (ERR !== e.err) begin failures++; $display("FAIL cs1_write_err: got %b want %b", ERR, e.err); end
        checks++; if (bus.ADO !== 16'h55AA || bus.AA !== e.aa) begin
            failures++; $display("FAIL cs1_write_bus: got ADO=%h AA=%h want 55aa %h", bus.ADO, bus.AA, e.aa); end
        checks++; if (wl_last !== 2 || wu_last !== 0 || rd_last !== 0) begin
            failures++; $display("FAIL cs1_write_strobes: got wrl=%0d wru=%0d rd=%0d want 2 0 0", wl_last, wu_last, rd_last); end
        checks++; if (cs_last !== 4 || idle_run !== 1) begin
            failures++; $display("FAIL cs1_write_timing: got cs=%0d ack_idle=%0d want 4 1", cs_last, idle_run); end
    endtask

    task automatic test_no_strobe_write();
        exp_t e; bit got;
        ce_period = 1; clear_mon();
        e = '{rdata: 16'h0, chk_rd: 1'b0, err: 1'b0, aa: 26'h0000100, chk_aa: 1'b1};
        drive_req(1'b1, 2'd0, 26'h0000100, 2'b00, 16'h1234, e);
        wait_ack(1'b0, 100, got);
        checks++; if (!got) begin failures++; $display("FAIL be00_ack: no ACK within 100 CLKs"); end
        if (sb.size() != 0) e = sb.pop_front();
        checks++; if (cs_last !== 6 || wl_last !== 0 || wu_last !== 0 || rd_last !== 0 || ERR !== e.err) begin
            failures++; $display("FAIL be00_timing: got cs=%0d wrl=%0d wru=%0d rd=%0d err=%b want 6 0 0 0 0", cs_last, wl_last, wu_last, rd_last, ERR); end
    endtask

    task automatic test_wait_ext();
        exp_t e; bit got;
        ce_period = 1; clear_mon(); bus.ADI = 16'h1357; aw_release = 18;
        e = '{rdata: 16'h1357, chk_rd: 1'b1, err: 1'b0, aa: 26'h3000004, chk_aa: 1'b1};
        drive_req(1'b0, 2'd2, 26'h3000004, 2'b11, 16'h0, e);
        wait_ack(1'b0, 200, got);
        aw_release = 0;
        checks++; if (!got) begin failures++; $display("FAIL wait_ack: no ACK within 200 CLKs"); end
        if (sb.size() != 0) e = sb.pop_front();
        checks++; if (rd_last !== 18 || cs_last !== 20) begin
            failures++; $display("FAIL wait_widths: got rd=%0d cs=%0d want 18 20", rd_last, cs_last); end
        checks++; if (RDATA !== e.rdata || ERR !== e.err) begin
            failures++; $display("FAIL wait_result: got rdata=%h err=%b want %h %b", RDATA, ERR, e.rdata, e.err); end
    endtask

    task automatic test_timeout();
        exp_t e; bit got;
        ce_period = 1; clear_mon(); bus.ADI = 16'h0F0F; aw_stuck = 1'b1;
        e = '{rdata: 16'hFFFF, chk_rd: 1'b1, err: 1'b1, aa: 26'h0000042, chk_aa: 1'b1};
        drive_req(1'b0, 2'd0, 26'h0000042, 2'b11, 16'h0, e);
        wait_ack(1'b0, 400, got);
        checks++; if (!got) begin failures++; $display("FAIL timeout_ack: no ACK within 400 CLKs"); end
        if (sb.size() != 0) e = sb.pop_front();
        checks++; if (ERR !== e.err || RDATA !== e.rdata) begin
            failures++; $display("FAIL timeout_result: got err=%b rdata=%h want %b %h", ERR, RDATA, e.err, e.rdata); end
        checks++; if (rd_last !== 259 || cs_last !== 261) begin
            failures++; $display("FAIL timeout_widths: got rd=%0d cs=%0d want 259 261", rd_last, cs_last); end
        aw_stuck = 1'b0;
        @(negedge CLK);
        #2;
        checks++; if (ERR !== 1'b0 || ACK !== 1'b0) begin
            failures++; $display("FAIL timeout_pulse: got ACK=%b ERR=%b one CLK later want 0 0", ACK, ERR); end
    endtask

    task automatic test_back_to_back();
        exp_t e1, e2, x; bit got; bit took;
        ce_period = 3; clear_mon(); bus.ADI = 16'h1111;
        e1 = '{rdata: 16'h1111, chk_rd: 1'b1, err: 1'b0, aa: 26'h0000A00, chk_aa: 1'b1};
        e2 = '{rdata: 16'h2222, chk_rd: 1'b1, err: 1'b0, aa: 26'h0000B00, chk_aa: 1'b1};
        drive_req(1'b0, 2'd0, 26'h0000A00, 2'b11, 16'h0, e1);
        took = 1'b0;
        for (int i = 0; i < 12 && !took; i++) begin @(negedge CLK); took = BUSY; end
        checks++; if (!took) begin failures++; $display("FAIL b2b_start: BUSY not seen within 12 CLKs"); end
        // Inputs change while busy; REQ stays high for the follow-on transfer
        ADDR = 26'h0000B00; WE = 1'b0; CS = 2'd0; BE = 2'b11;
        sb.push_back(e2);
        wait_ack(1'b1, 100, got);
        checks++; if (!got) begin failures++; $display("FAIL b2b_ack1: no ACK within 100 CLKs"); end
        x = sb.pop_front();
        checks++; if (RDATA !== x.rdata || bus.AA !== x.aa || ERR !== x.err) begin
            failures++; $display("FAIL b2b_first: got rdata=%h aa=%h err=%b want %h %h %b", RDATA, bus.AA, ERR, x.rdata, x.aa, x.err); end
        checks++; if (cs_last !== 18 || rd_last !== 12) begin
            failures++; $display("FAIL b2b_scaled: got cs=%0d rd=%0d want 18 12", cs_last, rd_last); end
        bus.ADI = 16'h2222;
        wait_ack(1'b0, 100, got);
        checks++; if (!got) begin failures++; $display("FAIL b2b_ack2: no ACK within 100 CLKs"); end
        if (sb.size() != 0) x = sb.pop_front();
        checks++; if (RDATA !== x.rdata || bus.AA !== x.aa) begin
            failures++; $display("FAIL b2b_second: got rdata=%h aa=%h want %h %h", RDATA, bus.AA, x.rdata, x.aa); end
        checks++; if (idle_last !== 3) begin failures++; $display("FAIL b2b_idle_gap: got %0d CLKs want 3", idle_last); end
    endtask

    task automatic test_reserved_cs();
        exp_t e; bit got;
        ce_period = 3; clear_mon();
        e = '{rdata: 16'h0, chk_rd: 1'b0, err: 1'b1, aa: 26'h0, chk_aa: 1'b0};
        drive_req(1'b0, 2'd3, 26'h1555555, 2'b11, 16'h0, e);
        wait_ack(1'b0, 20, got);
        checks++; if (!got) begin failures++; $display("FAIL cs3_ack: no ACK within 20 CLKs"); end
        if (sb.size() != 0) e = sb.pop_front();
        checks++; if (ERR !== e.err) begin failures++; $display("FAIL cs3_err: got %b want %b", ERR, e.err); end
        repeat (6) @(negedge CLK);
        #2;
        checks++; if (busy_seen || cs_run !== 0 || cs_last !== 0 || rd_last !== 0) begin
            failures++; $display("FAIL cs3_no_bus: got busy=%b cs_run=%0d cs=%0d rd=%0d want 0 0 0 0", busy_seen, cs_run, cs_last, rd_last); end
    endtask

    task automatic test_reset_abort();
        bit in_strobe; int acks;
        ce_period = 3; clear_mon(); bus.ADI = 16'h7777;
        WE = 1'b0; CS = 2'd2; ADDR = 26'h0ABCDE0; BE = 2'b11; REQ = 1'b1;
        in_strobe = 1'b0;
        for (int i = 0; i < 40 && !in_strobe; i++) begin
            @(negedge CLK);
            if (BUSY) REQ = 1'b0;
            in_strobe = !bus.ARD_N;
        end
        checks++; if (!in_strobe) begin failures++; $display("FAIL abort_strobe: ARD_N never low within 40 CLKs"); end
        repeat (2) @(negedge CLK);
        acks = ack_count;
        RST = 1'b1;
        @(negedge CLK);
        #2;
        checks++; if ({bus.ACS2_N, bus.ACS1_N, bus.ACS0_N, bus.ARD_N, bus.AWRL_N, bus.AWRU_N} !== 6'b111111 || BUSY !== 1'b0) begin
            failures++; $display("FAIL abort_idle: got pins=%b busy=%b want 111111 0", {bus.ACS2_N, bus.ACS1_N, bus.ACS0_N, bus.ARD_N, bus.AWRL_N, bus.AWRU_N}, BUSY); end
        checks++; if (bus.AA !== 26'h0 || RDATA !== 16'h0 || ACK !== 1'b0) begin
            failures++; $display("FAIL abort_regs: got AA=%h RDATA=%h ACK=%b want 0 0 0", bus.AA, RDATA, ACK); end
        RST = 1'b0;
        repeat (30) @(negedge CLK);
        #2;
        checks++; if (ack_count !== acks || BUSY !== 1'b0) begin
            failures++; $display("FAIL abort_no_ack: got acks=%0d busy=%b want %0d 0", ack_count, BUSY, acks); end
    endtask

    task automatic test_invariants();
        checks++; if (inv_viol !== 0) begin failures++; $display("FAIL invariants: got %0d violations want 0", inv_viol); end
        checks++; if (sb.size() !== 0) begin failures++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_cs0_read();
        test_cs1_write();
        test_no_strobe_write();
        test_wait_ext();
        test_timeout();
        test_back_to_back();
        test_reserved_cs();
        test_reset_abort();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/abus_initiator.md
ABUS_INITIATOR -- requirements
Module: abus_initiator

Interface
REQ-001 SHALL have parameter WAIT_CS0, default 3, meaning minimum strobe-low CE_R ticks minus one for CS0 cycles (4-bit).
REQ-002 SHALL have parameter WAIT_CS1, default 1, same meaning for CS1.
REQ-003 SHALL have parameter WAIT_CS2, default 7, same meaning for CS2.
REQ-004 SHALL have parameter TIMEOUT, default 255, meaning max CE_R ticks AWAIT_N may extend a strobe (8-bit).
REQ-005 CLK  in  1  system clock; the only clock.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 CE_R  in  1  bus-tick enable; all state advances occur only on CLK edges with CE_R=1.
REQ-008 REQ  in  1  transfer request, level, sampled in IDLE on CE_R.
REQ-009 WE  in  1  1=write, 0=read.
REQ-010 CS  in  2  target select: 0=CS0, 1=CS1, 2=CS2, 3=reserved.
REQ-011 ADDR  in  26  byte address.
REQ-012 BE  in  2  byte enables, [1]=upper, [0]=lower.
REQ-013 WDATA  in  16  write data.
REQ-014 RDATA  out  16  read data, valid with ACK.
REQ-015 ACK  out  1  one-CLK completion pulse.
REQ-016 ERR  out  1  one-CLK pulse with ACK on timeout or reserved CS.
REQ-017 BUSY  out  1  high in any state other than IDLE.
REQ-018 AA  out  26  A-bus address.
REQ-019 ADO  out  16  A-bus write data.
REQ-020 ADI  in  16  A-bus read data.
REQ-021 ACS0_N/ACS1_N/ACS2_N  out  1 each  chip selects, active-low.
REQ-022 ARD_N, AWRL_N, AWRU_N  out  1 each  read/lower-write/upper-write strobes, active-low.
REQ-023 AWAIT_N  in  1  responder wait, active-low.

Function
REQ-024 SHALL implement states IDLE, SETUP, STROBE, HOLD.
REQ-025 IDLE: on CE_R with REQ=1, SHALL latch WE, CS, ADDR, BE, WDATA, go to SETUP; REQ with CS=3 SHALL instead pulse ACK+ERR next CLK, no bus activity.
REQ-026 SETUP (1 tick): selected ACSx_N=0, AA=latched ADDR, ADO=latched WDATA, all strobes high; then STROBE.
REQ-027 STROBE: ARD_N=0 for reads; for writes AWRU_N=~BE[1], AWRL_N=~BE[0]; BE=00 write SHALL assert no strobe but time identically.
REQ-028 STROBE SHALL last at least WAIT_CSx+1 ticks (4-bit counter); once minimum met, SHALL extend while AWAIT_N=0.
REQ-029 AWAIT_N SHALL be sampled only on CE_R ticks; timeout counter counts extension ticks, reset on entering STROBE.
REQ-030 Extension reaching TIMEOUT ticks SHALL end STROBE, flagging ERR; RDATA=16'hFFFF on read timeout.
REQ-031 Normal read end: RDATA SHALL capture ADI on the CE_R tick on which STROBE ends.
REQ-032 HOLD (1 tick): strobes high, ACSx_N still low, AA/ADO held; at end all ACSx_N high, ACK (and ERR if flagged) pulse for exactly one CLK, go IDLE.
REQ-033 Back-to-back: REQ high at ACK SHALL start next SETUP no earlier than the next CE_R tick after returning to IDLE (min 1 idle tick, all CS high).
REQ-034 REQ and input changes outside IDLE SHALL be ignored; latched values govern the cycle.
REQ-035 At most one ACSx_N low at any time; strobes low only in STROBE.
REQ-036 CE_R=0 SHALL freeze all state, counters, and bus outputs.
REQ-037 Total ticks, no wait: 1 + (WAIT_CSx+1) + 1 (+ extension).

Reset
REQ-038 RST=1 on a CLK edge SHALL, regardless of CE_R, force IDLE, all ACSx_N/ARD_N/AWRL_N/AWRU_N=1, AA=0, ADO=0, RDATA=0, ACK=0, ERR=0, BUSY=0, counters 0.
REQ-039 RST mid-cycle SHALL abort the transfer with no ACK; strobes deassert the next CLK.

Verification
REQ-040 CS0 read, ADDR=26'h0001234, CE_R every CLK, AWAIT_N=1, ADI=16'hBEEF -> ACS0_N low 6 ticks, ARD_N low 4 ticks, ACK with RDATA=16'hBEEF, ERR=0.
REQ-041 CS1 write WDATA=16'h55AA, BE=01 -> AWRL_N low 2 ticks, AWRU_N stays 1, ADO=16'h55AA throughout, ACK at tick 5.
REQ-042 CS2 read, AWAIT_N held 0 for 10 ticks after minimum -> ARD_N low 18 ticks, ACK, ERR=0.
REQ-043 CS0 read, AWAIT_N stuck 0 -> STROBE ends after 4+255 ticks, ACK+ERR, RDATA=16'hFFFF.
REQ-044 CE_R every 3rd CLK, back-to-back CS0 reads, CS=3 request, RST asserted in STROBE -> timing scales by 3, 1 idle tick between cycles, CS=3 gives ACK+ERR with no CS, RST yields idle bus next CLK and no ACK.
